// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller: FETCH over a req/ack ROM handshake, then a single EXEC cycle
// that drives the external ALU and commits A/D/PC/writeM. Minimum 2 cycles per instruction.
module hack_cpu_ctrl (
  input  logic        clk,
  input  logic        reset,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] instruction,
  input  logic [15:0] inM,
  output logic [14:0] addressM,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic [15:0] instret
);

  typedef enum logic {ST_FETCH, ST_EXEC} state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] instret_q, instret_d;

  logic is_exec, is_c_exec, jump;

  assign is_exec   = (state_q == ST_EXEC);
  assign is_c_exec = is_exec && ir_q[15];
  assign jump      = (ir_q[2] && alu_ng) || (ir_q[1] && alu_zr) ||
                     (ir_q[0] && !alu_ng && !alu_zr);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    a_d       = a_q;
    d_d       = d_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    case (state_q)
      ST_FETCH: begin
        if (rom_ack) begin
          ir_d    = instruction;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instret_d = instret_q + 16'd1;
        state_d   = ST_FETCH;
        if (!ir_q[15]) begin
          a_d  = {1'b0, ir_q[14:0]};
          pc_d = pc_q + 15'd1;
        end else begin
          // Jump target and operands use the pre-edge A even when A is a destination.
          if (ir_q[5]) a_d = alu_out;
          if (ir_q[4]) d_d = alu_out;
          pc_d = jump ? a_q[14:0] : pc_q + 15'd1;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      ir_q      <= 16'd0;
      a_q       <= 16'd0;
      d_q       <= 16'd0;
      pc_q      <= 15'd0;
      instret_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      d_q       <= d_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  assign rom_req  = !reset && !is_exec;
  assign rom_addr = pc_q;
  assign addressM = a_q[14:0];
  assign outM     = alu_out;
  assign writeM   = !reset && is_c_exec && ir_q[3];
  assign alu_x    = d_q;
  assign alu_y    = ir_q[12] ? inM : a_q;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = is_c_exec ? ir_q[11:6] : 6'b0;
  assign pc       = pc_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: ROM/data-memory/ALU environment plus an instruction-level Hack reference model.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_ack;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] alu_x, alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic [14:0] pc;
  logic [15:0] instret;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom   [64];
  logic [15:0] dmem  [256];
  logic [15:0] m_mem [256];

  // Reference architectural state
  bit          m_fetch;
  logic [14:0] m_pc;
  logic [15:0] m_a, m_d, m_ir, m_instret;

  hack_cpu_ctrl dut (
    .clk(clk), .reset(reset),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .instruction(instruction),
    .inM(inM), .addressM(addressM), .outM(outM), .writeM(writeM),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'd0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'd0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~o : o;
  endfunction

  // External combinational ALU and zero-wait data memory
  assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign alu_zr  = (alu_out == 16'd0);
  assign alu_ng  = alu_out[15];
  assign inM     = dmem[addressM[7:0]];

  always @(posedge clk) if (writeM === 1'b1) dmem[addressM[7:0]] <= outM;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h pc=%h t=%0t", tag, got, exp, m_pc, $time);
    end
  endtask

  task automatic model_reset();
    m_fetch = 1'b1; m_pc = '0; m_a = '0; m_d = '0; m_ir = '0; m_instret = '0;
  endtask

  task automatic step(input bit rst, input bit ack);
    bit          exec_c, jmp;
    logic [15:0] y, o;
    reset       = rst;
    rom_ack     = ack;
    instruction = ack ? rom[rom_addr[5:0]] : 16'($urandom);
    @(negedge clk);
    exec_c = !m_fetch && m_ir[15];
    y = m_ir[12] ? m_mem[m_a[7:0]] : m_a;
    o = hack_alu(m_d, y, m_ir[11:6]);
    check_val("rom_req",  16'(rom_req), 16'(!rst && m_fetch));
    check_val("rom_addr", 16'(rom_addr), 16'(m_pc));
    check_val("pc",       16'(pc), 16'(m_pc));
    check_val("instret",  instret, m_instret);
    check_val("writeM",   16'(writeM), 16'(!rst && exec_c && m_ir[3]));
    check_val("addressM", 16'(addressM), 16'(m_a[14:0]));
    check_val("alu_x",    alu_x, m_d);
    check_val("alu_y",    alu_y, y);
    check_val("alu_ctrl", 16'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}),
              exec_c ? 16'(m_ir[11:6]) : 16'd0);
    if (!rst && exec_c && m_ir[3]) check_val("outM", outM, o);
    // Advance the architectural model by one cycle
    if (rst) begin
      model_reset();
    end else if (m_fetch) begin
      if (ack) begin
        m_ir    = rom[m_pc[5:0]];
        m_fetch = 1'b0;
      end
    end else begin
      m_instret = m_instret + 16'd1;
      m_fetch   = 1'b1;
      if (!m_ir[15]) begin
        m_a  = {1'b0, m_ir[14:0]};
        m_pc = m_pc + 15'd1;
      end else begin
        jmp = (m_ir[2] && o[15]) || (m_ir[1] && o == 16'd0) || (m_ir[0] && !o[15] && o != 16'd0);
        if (m_ir[3]) m_mem[m_a[7:0]] = o;
        m_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
        if (m_ir[5]) m_a = o;
        if (m_ir[4]) m_d = o;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; rom_ack = 1'b0; instruction = '0;
    for (int i = 0; i < 256; i++) begin dmem[i] = '0; m_mem[i] = '0; end
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h0005;  // @5
    rom[1]  = 16'hEC10;  // D=A
    rom[2]  = 16'hE308;  // M=D
    rom[3]  = 16'h0010;  // @16
    rom[4]  = 16'hE301;  // D;JGT  (taken, D=5)
    rom[16] = 16'hEA90;  // D=0
    rom[17] = 16'hE301;  // D;JGT  (not taken)
    rom[18] = 16'h7FFF;  // @32767
    rom[19] = 16'hEA87;  // 0;JMP -> pc=0x7FFF, fetches rom[63]
    rom[63] = 16'h0000;  // @0 at 0x7FFF, pc wraps to 0
    model_reset();
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b0, !(i inside {12, 13, 14}));

    // Reset landing on the EXEC cycle of M=D
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      rom[i] = (r[31:30] == 2'b00) ? {1'b0, r[14:0]} :
               (r[31:30] == 2'b01) ? {10'd0, r[5:0]} : {3'b111, r[12:0]};
    end
    step(1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) step(($urandom % 60) == 0, ($urandom % 3) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle Hack CPU controller that sits on the initiator side of the ALU. It fetches instructions from ROM over a req/ack handshake and decodes A- and C-instructions. It drives operands and the zx/nx/zy/ny/f/no controls into the external combinational ALU, then consumes out/zr/ng to update the A, D and PC registers and issue data-memory writes.

## Interface
- No parameters; all widths are fixed by the Hack ISA.
- clk  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rom_req  out  1  instruction fetch request
- rom_addr  out  15  fetch address, equal to pc
- rom_ack  in  1  instruction valid this cycle
- instruction  in  16  ROM data, sampled only when rom_req && rom_ack
- inM  in  16  data-memory read data, combinational from addressM
- addressM  out  15  data-memory address, equal to A[14:0]
- outM  out  16  data-memory write data, equal to alu_out
- writeM  out  1  data-memory write strobe, committed by memory on the same edge
- alu_x  out  16  ALU x operand, equal to D
- alu_y  out  16  ALU y operand: inM when ir[12]=1, else A
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU controls, equal to ir[11:6] in that order
- alu_out  in  16  ALU result
- alu_zr  in  1  ALU result is zero
- alu_ng  in  1  ALU result is negative
- pc  out  15  program counter
- instret  out  16  retired-instruction counter

## Operation
- Internal registers: ir[15:0], A[15:0], D[15:0], pc[14:0], instret[15:0], and a 1-bit state (FETCH, EXEC).
- FETCH:
  - rom_req=1, rom_addr=pc.
  - On rom_ack: ir<=instruction; go to EXEC.
  - Without rom_ack: stay in FETCH; pc and rom_addr hold stable.
- EXEC, A-instruction (ir[15]=0):
  - A <= {1'b0, ir[14:0]}; pc <= pc+1.
  - Go to FETCH.
- EXEC, C-instruction (ir[15]=1):
  - ir[14:13] are ignored.
  - ALU controls come from ir[11:6].
  - Destinations:
    - ir[5]: A <= alu_out
    - ir[4]: D <= alu_out
    - ir[3]: writeM=1 for this cycle only
  - Jump conditions:
    - ir[2]: taken if alu_ng
    - ir[1]: taken if alu_zr
    - ir[0]: taken if !alu_ng && !alu_zr
    - Any set condition that holds makes the jump taken.
  - Taken: pc <= A[14:0]. Not taken: pc <= pc+1.
  - Go to FETCH.
- Every EXEC increments instret.
- Old-value rule: addressM, alu_y and the jump target all use the value of A from before the EXEC edge, even when ir[5]=1.
- ALU controls are all 0 outside EXEC and during A-instruction EXEC. alu_x and alu_y are always driven.
- writeM is 0 in every cycle except a C-instruction EXEC with ir[3]=1.
- Wrap-around: pc wraps 0x7FFF→0x0000; instret wraps 0xFFFF→0x0000.
- rom_ack while in EXEC is ignored.

## Timing
- Reset values, after any edge with reset=1:
  - A=0, D=0, pc=0, ir=0, instret=0, state=FETCH.
- While reset=1, rom_req and writeM are forced 0, combinationally gated.
- First rom_req=1 appears in the cycle after reset deasserts.
- Reset asserted in EXEC: no write occurs, no register updates except the reset values.
- Reset asserted in FETCH: a pending ack is discarded.
- Latency:
  - Minimum 2 cycles per instruction (ack in the first FETCH cycle, then EXEC).
  - Each cycle of ROM wait adds one cycle.
- Data memory has zero wait states. inM must be valid in the same cycle as addressM.

## Test plan
- Reset: hold reset 3 cycles, with rom_ack=1 throughout.
  - During reset: rom_req=0, writeM=0.
  - After release: pc=0, instret=0, rom_req=1, rom_addr=0.
- 0x0005 (@5) with immediate ack:
  - EXEC in cycle 2, A=5, pc=1, instret=1.
  - Next FETCH has rom_addr=1.
- After @5, 0xEC10 (D=A), with the ALU model returning 5:
  - In EXEC: ALU controls 110000, alu_y=5.
  - Afterwards: D=5, writeM stays 0.
- After D=5, 0xE308 (M=D):
  - EXEC shows writeM=1 for exactly one cycle, addressM=5, outM=5, alu_x=5.
  - pc increments.
- 0xE301 (D;JGT) with A=0x0010:
  - ALU returns 3 (ng=0, zr=0): pc=0x0010.
  - Repeated with ALU returning 0: pc=old pc+1.
  - 0xEA87 (0;JMP) always gives pc=A.
- Handshake and reset:
  - rom_ack delayed 3 cycles: rom_req stays 1 and rom_addr stays constant, then EXEC follows.
  - Reset asserted during an M=D EXEC: writeM=0 that cycle; A, D and pc all return to 0.
